// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling path.
package pool_pkg;

    typedef enum logic [1:0] {
        OP_AVG = 2'b00,
        OP_MIN = 2'b01,
        OP_MAX = 2'b10,
        OP_SUM = 2'b11
    } op_t;

    // Internal arithmetic is done at a fixed wide width; DATA_W + WIN_LOG2 must fit.
    localparam int unsigned MaxW = 64;
    typedef logic [MaxW-1:0] wide_t;
    typedef logic [$clog2(MaxW)-1:0] wide_idx_t;

    typedef struct packed {
        logic  sat;
        wide_t val;
    } clip_t;

    // Extend the low w bits of d to MaxW bits, replicating bit w-1 when sgn is set.
    function automatic wide_t ext(input wide_t d, input int unsigned w, input bit sgn);
        wide_t     r;
        wide_idx_t msb;
        msb = wide_idx_t'(w - 1);
        for (int i = 0; i < int'(MaxW); i++) begin
            r[i] = (i < int'(w)) ? d[i] : (sgn & d[msb]);
        end
        return r;
    endfunction

    // Clamp a sign-extended wide value into the w-bit range; sat flags a clamp.
    function automatic clip_t sat_clip(input wide_t v, input int unsigned w, input bit sgn);
        logic signed [MaxW-1:0] sv;
        logic signed [MaxW-1:0] hi;
        logic signed [MaxW-1:0] lo;
        clip_t                  c;
        sv = v;
        if (sgn) begin
            hi = (64'sd1 <<< (w - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (w - 1));
        end else begin
            hi = (64'sd1 <<< w) - 64'sd1;
            lo = '0;
        end
        c.sat = 1'b0;
        c.val = v;
        if (sv > hi) begin
            c.val = hi;
            c.sat = 1'b1;
        end else if (sv < lo) begin
            c.val = lo;
            c.sat = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pool_out_reg.sv
// Single-entry result register with valid/ready hold.
module pool_out_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         res,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         sat_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         sat_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         sat_q, sat_d;

    // A load wins over a drain, so drain+load in one cycle keeps valid high with new data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sat_d   = sat_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            sat_d   = sat_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/pool_reduce_unit.sv
// Reduces each window of 2**WIN_LOG2 samples to one AVG/MIN/MAX/SUM result.
module pool_reduce_unit
    import pool_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WIN_LOG2 = 2,
    parameter bit          SIGNED   = 1'b0
) (
    input  logic              clk,
    input  logic              res,
    input  logic [1:0]        op_type_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_sat_o
);

    localparam int unsigned ACC_W = DATA_W + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CntLast = '1;
    localparam logic [WIN_LOG2-1:0] CntOne  = WIN_LOG2'(1);

    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    op_t                 op_q, op_d;

    logic  accept, load, res_sat;
    wide_t samp_w, acc_w, comb_w, res_w;
    clip_t clip;
    logic  unused_res;

    // Only the window-closing sample stalls, and only while the result slot is full.
    assign in_ready_o = !(cnt_q == CntLast && out_valid_o && !out_ready_i);
    assign accept     = in_valid_i && in_ready_o && !flush_i;
    assign load       = accept && (cnt_q == CntLast);

    // Combine the running accumulator with the incoming sample and format the result.
    always_comb begin
        samp_w = ext(wide_t'(in_data_i), DATA_W, SIGNED);
        acc_w  = ext(wide_t'(acc_q), ACC_W, SIGNED);
        // Both operands are extended into the wide signed range, so one signed compare
        // serves the unsigned case too.
        case (op_q)
            OP_MIN:  comb_w = ($signed(samp_w) < $signed(acc_w)) ? samp_w : acc_w;
            OP_MAX:  comb_w = ($signed(samp_w) > $signed(acc_w)) ? samp_w : acc_w;
            default: comb_w = acc_w + samp_w;
        endcase
        clip    = sat_clip(comb_w, DATA_W, SIGNED);
        res_sat = 1'b0;
        case (op_q)
            OP_AVG:  res_w = wide_t'($signed(comb_w) >>> WIN_LOG2);
            OP_SUM: begin
                res_w   = clip.val;
                res_sat = clip.sat;
            end
            default: res_w = comb_w;
        endcase
    end

    assign unused_res = ^res_w[MaxW-1:DATA_W];

    // Window counter, accumulator and latched op.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        op_d  = op_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + CntOne;
            if (cnt_q == '0) begin
                acc_d = samp_w[ACC_W-1:0];
                op_d  = op_t'(op_type_i);
            end else begin
                acc_d = comb_w[ACC_W-1:0];
            end
        end
    end

    // Window state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q <= '0;
            acc_q <= '0;
            op_q  <= OP_AVG;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            op_q  <= op_d;
        end
    end

    pool_out_reg #(
        .W(DATA_W)
    ) u_out_reg (
        .clk     (clk),
        .res     (res),
        .load_i  (load),
        .data_i  (res_w[DATA_W-1:0]),
        .sat_i   (res_sat),
        .valid_o (out_valid_o),
        .ready_i (out_ready_i),
        .data_o  (out_data_o),
        .sat_o   (out_sat_o)
    );

endmodule

// File: tb/tb_pool_reduce_unit.sv
// Directed bench for pool_reduce_unit: one unsigned and one signed instance share stimulus.
module tb_pool_reduce_unit;

    logic        clk = 1'b0;
    logic        res;
    logic [1:0]  op_type;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready_u, out_valid_u, out_sat_u;
    logic [15:0] out_data_u;
    logic        in_ready_s, out_valid_s, out_sat_s;
    logic [15:0] out_data_s;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pool_reduce_unit #(
        .DATA_W   (16),
        .WIN_LOG2 (2),
        .SIGNED   (1'b0)
    ) u_dut_u (
        .clk         (clk),
        .res         (res),
        .op_type_i   (op_type),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_u),
        .in_data_i   (in_data),
        .out_valid_o (out_valid_u),
        .out_ready_i (out_ready),
        .out_data_o  (out_data_u),
        .out_sat_o   (out_sat_u)
    );

    pool_reduce_unit #(
        .DATA_W   (16),
        .WIN_LOG2 (2),
        .SIGNED   (1'b1)
    ) u_dut_s (
        .clk         (clk),
        .res         (res),
        .op_type_i   (op_type),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_s),
        .in_data_i   (in_data),
        .out_valid_o (out_valid_s),
        .out_ready_i (out_ready),
        .out_data_o  (out_data_s),
        .out_sat_o   (out_sat_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] op);
        in_valid = 1'b1;
        in_data  = d;
        op_type  = op;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        res       = 1'b1;
        op_type   = 2'b00;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid_u), 32'd0);
        chk("rst_data", 32'(out_data_u), 32'd0);
        chk("rst_sat", 32'(out_sat_u), 32'd0);
        chk("rst_ready", 32'(in_ready_u), 32'd1);
        res = 1'b0;
        idle();

        // Unsigned AVG: (10+20+30+41)/4 = 25
        send(16'd10, 2'b00);
        send(16'd20, 2'b00);
        send(16'd30, 2'b00);
        chk("avg_not_yet", 32'(out_valid_u), 32'd0);
        send(16'd41, 2'b00);
        chk("avg_valid", 32'(out_valid_u), 32'd1);
        chk("avg_data", 32'(out_data_u), 32'd25);
        chk("avg_sat", 32'(out_sat_u), 32'd0);
        idle();
        chk("avg_drained", 32'(out_valid_u), 32'd0);

        // Signed MIN then MAX back-to-back; mid-window op changes are ignored.
        send(16'hFFFB, 2'b01);
        send(16'd3, 2'b10);
        send(16'hFFF9, 2'b10);
        send(16'd2, 2'b11);
        chk("smin_valid", 32'(out_valid_s), 32'd1);
        chk("smin_data", 32'(out_data_s), 32'h0000FFF9);
        send(16'hFFFB, 2'b10);
        send(16'd3, 2'b01);
        send(16'hFFF9, 2'b00);
        send(16'd2, 2'b11);
        chk("smax_valid", 32'(out_valid_s), 32'd1);
        chk("smax_data", 32'(out_data_s), 32'd3);
        chk("smax_sat", 32'(out_sat_s), 32'd0);

        // Unsigned SUM saturation, then an in-range sum with no bubble.
        send(16'hFFFF, 2'b11);
        send(16'hFFFF, 2'b00);
        send(16'd1, 2'b00);
        send(16'd0, 2'b00);
        chk("sum_sat_data", 32'(out_data_u), 32'h0000FFFF);
        chk("sum_sat_flag", 32'(out_sat_u), 32'd1);
        send(16'd1, 2'b11);
        send(16'd2, 2'b00);
        send(16'd3, 2'b00);
        send(16'd4, 2'b00);
        chk("sum_data", 32'(out_data_u), 32'd10);
        chk("sum_flag", 32'(out_sat_u), 32'd0);
        chk("sum_valid", 32'(out_valid_u), 32'd1);
        idle();

        // Backpressure: second window stalls only at its last sample.
        send(16'd4, 2'b00);
        send(16'd4, 2'b00);
        send(16'd4, 2'b00);
        send(16'd4, 2'b00);
        chk("bp_first", 32'(out_data_u), 32'd4);
        out_ready = 1'b0;
        send(16'd8, 2'b00);
        chk("bp_ready_s2", 32'(in_ready_u), 32'd1);
        send(16'd8, 2'b00);
        send(16'd8, 2'b00);
        chk("bp_ready_s4", 32'(in_ready_u), 32'd0);
        send(16'd8, 2'b00);
        chk("bp_hold_valid", 32'(out_valid_u), 32'd1);
        chk("bp_hold_data", 32'(out_data_u), 32'd4);
        chk("bp_still_stall", 32'(in_ready_u), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_up", 32'(in_ready_u), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_swap_valid", 32'(out_valid_u), 32'd1);
        chk("bp_swap_data", 32'(out_data_u), 32'd8);
        idle();
        chk("bp_no_dup", 32'(out_valid_u), 32'd0);

        // Flush after two samples; the next four form a clean window.
        send(16'd9, 2'b00);
        send(16'd9, 2'b00);
        flush = 1'b1;
        send(16'd9, 2'b00);
        flush = 1'b0;
        chk("fl_no_out", 32'(out_valid_u), 32'd0);
        send(16'd1, 2'b00);
        send(16'd1, 2'b00);
        chk("fl_none_2", 32'(out_valid_u), 32'd0);
        send(16'd1, 2'b00);
        chk("fl_none_3", 32'(out_valid_u), 32'd0);
        send(16'd1, 2'b00);
        chk("fl_valid", 32'(out_valid_u), 32'd1);
        chk("fl_data", 32'(out_data_u), 32'd1);
        idle();
        chk("fl_one_only", 32'(out_valid_u), 32'd0);

        // Reset with a held result and a partial window.
        out_ready = 1'b0;
        send(16'd5, 2'b00);
        send(16'd5, 2'b00);
        send(16'd5, 2'b00);
        send(16'd5, 2'b00);
        chk("rs_held", 32'(out_data_u), 32'd5);
        send(16'd7, 2'b00);
        send(16'd7, 2'b00);
        send(16'd7, 2'b00);
        res      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        res = 1'b0;
        chk("rs_valid", 32'(out_valid_u), 32'd0);
        chk("rs_data", 32'(out_data_u), 32'd0);
        out_ready = 1'b1;
        send(16'd2, 2'b00);
        send(16'd2, 2'b00);
        send(16'd2, 2'b00);
        chk("rs_fresh_wait", 32'(out_valid_u), 32'd0);
        send(16'd6, 2'b00);
        chk("rs_fresh_valid", 32'(out_valid_u), 32'd1);
        chk("rs_fresh_data", 32'(out_data_u), 32'd3);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
